branch_resolve_ctrl: RTL and testbench

//  Sequences conditional-branch resolution for the core. Holds the architectural

---
 rtl/branch_resolve_ctrl.sv | 138 +++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: conditional-branch sequencer.
// Holds the {N,Z,C,V} flag register. It accepts one branch from decode and
// waits for an in-flight flag-setting op when the condition needs flags.
// It then resolves the branch and drives the PC-load and flush controls.
// Optional feature macro: FLAG_FWD_EN. When it is defined, a branch waiting on
// flags resolves in the same cycle as the flag write, using FlagIn directly.
module branch_resolve_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int FLUSH_CYC = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [3:0]        FlagIn,
    input  logic              FlagWe,
    input  logic              FlagPend,
    input  logic              BrValid,
    input  logic [1:0]        BrCond,
    input  logic [ADDR_W-1:0] BrTarget,
    output logic              BrReady,
    output logic              Stall,
    output logic              BrDone,
    output logic              BrTaken,
    output logic              PcLoad,
    output logic [ADDR_W-1:0] PcTarget,
    output logic              Flush,
    output logic [3:0]        FlagReg
);

    localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;
    // The FLUSH state covers every Flush cycle after the PcLoad cycle.
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EVAL, S_FLUSH} state_t;

    state_t          state, state_nxt;
    logic [1:0]      cond_q;
    logic [CW-1:0]   flush_cnt;
    logic            load_cnt;

    // Condition code against a flag vector: 00 always, 01 EQ, 10 GE, 11 LT.
    function automatic logic cond_true(input logic [1:0] c, input logic [3:0] f);
        case (c)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = f[2];
            2'b10:   cond_true = ~f[3];
            default: cond_true = f[3];
        endcase
    endfunction

    // Architectural flags are written by the ALU in every state.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) FlagReg <= 4'h0;
        else if (FlagWe) FlagReg <= FlagIn;
    end

    // Latch the condition and target of the accepted branch.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cond_q   <= 2'b00;
            PcTarget <= '0;
        end else if (state == S_IDLE && BrValid) begin
            cond_q   <= BrCond;
            PcTarget <= BrTarget;
        end
    end

    // State register and the flush-length counter.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= S_IDLE;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_cnt) flush_cnt <= FLUSH_LOAD;
            else if (state == S_FLUSH) flush_cnt <= flush_cnt - CNT_ONE;
        end
    end

    // Next state and decoded control outputs.
    always_comb begin
        state_nxt = state;
        load_cnt  = 1'b0;
        BrReady   = 1'b0;
        Stall     = 1'b1;
        BrDone    = 1'b0;
        BrTaken   = 1'b0;
        PcLoad    = 1'b0;
        Flush     = 1'b0;
        case (state)
            S_IDLE: begin
                BrReady = 1'b1;
                Stall   = 1'b0;
                if (BrValid) begin
                    if (FlagPend && BrCond != 2'b00) state_nxt = S_WAIT;
                    else state_nxt = S_EVAL;
                end
            end
            S_WAIT: begin
                if (FlagWe) begin
`ifdef FLAG_FWD_EN
                    // Resolve now on the forwarded flags.
                    BrDone  = 1'b1;
                    BrTaken = cond_true(cond_q, FlagIn);
                    PcLoad  = BrTaken;
                    Flush   = BrTaken;
                    if (BrTaken && FLUSH_CYC > 1) begin
                        state_nxt = S_FLUSH;
                        load_cnt  = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
`else
                    state_nxt = S_EVAL;
`endif
                end
            end
            S_EVAL: begin
                // Only the registered flags count; a same-cycle write is too late.
                BrDone  = 1'b1;
                BrTaken = cond_true(cond_q, FlagReg);
                PcLoad  = BrTaken;
                Flush   = BrTaken;
                if (BrTaken && FLUSH_CYC > 1) begin
                    state_nxt = S_FLUSH;
                    load_cnt  = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                Flush = 1'b1;
                if (flush_cnt <= CNT_ONE) state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios followed by random traffic.
// The bench models a branch as one outstanding transaction.
// It tracks whether the branch waits on flags, whether it resolves this cycle,
// and how many flush cycles remain.
module tb_branch_resolve_ctrl;
    localparam int ADDR_W    = 16;
    localparam int FLUSH_CYC = 2;

    logic              Clock = 1'b0;
    logic              Resetn = 1'b0;
    logic [3:0]        FlagIn = '0;
    logic              FlagWe = 1'b0;
    logic              FlagPend = 1'b0;
    logic              BrValid = 1'b0;
    logic [1:0]        BrCond = '0;
    logic [ADDR_W-1:0] BrTarget = '0;
    logic              BrReady, Stall, BrDone, BrTaken, PcLoad, Flush;
    logic [ADDR_W-1:0] PcTarget;
    logic [3:0]        FlagReg;

    branch_resolve_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC)) dut (
        .Clock(Clock), .Resetn(Resetn), .FlagIn(FlagIn), .FlagWe(FlagWe),
        .FlagPend(FlagPend), .BrValid(BrValid), .BrCond(BrCond),
        .BrTarget(BrTarget), .BrReady(BrReady), .Stall(Stall), .BrDone(BrDone),
        .BrTaken(BrTaken), .PcLoad(PcLoad), .PcTarget(PcTarget), .Flush(Flush),
        .FlagReg(FlagReg)
    );

    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time.
    logic              m_busy, m_waiting, m_resolve;
    int                m_flush_left;
    logic [1:0]        m_cond;
    logic [ADDR_W-1:0] m_tgt;
    logic [3:0]        m_flags;

    function automatic logic taken_of(input logic [1:0] c, input logic [3:0] f);
        logic r;
        r = 1'b0;
        if (c == 2'd0) r = 1'b1;
        else if (c == 2'd1) r = f[2];
        else if (c == 2'd2) r = !f[3];
        else r = f[3];
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_waiting = 0; m_resolve = 0; m_flush_left = 0;
        m_cond = '0; m_tgt = '0; m_flags = '0;
    endtask

    // Compare outputs with the model, then advance the model across the next edge.
    task automatic check_and_advance();
        logic done_e, taken_e, fwd;
        fwd = 1'b0;
`ifdef FLAG_FWD_EN
        fwd = 1'b1;
`endif
        done_e  = m_resolve || (fwd && m_waiting && FlagWe);
        taken_e = 1'b0;
        if (m_resolve) taken_e = taken_of(m_cond, m_flags);
        else if (done_e) taken_e = taken_of(m_cond, FlagIn);
        chk("ready",  32'(BrReady),  32'(!m_busy));
        chk("stall",  32'(Stall),    32'(m_busy));
        chk("done",   32'(BrDone),   32'(done_e));
        chk("taken",  32'(BrTaken),  32'(done_e && taken_e));
        chk("pcload", 32'(PcLoad),   32'(done_e && taken_e));
        chk("flush",  32'(Flush),    32'((done_e && taken_e) || m_flush_left > 0));
        chk("target", 32'(PcTarget), 32'(m_tgt));
        chk("flags",  32'(FlagReg),  32'(m_flags));
        // Advance the model across the next clock edge.
        if (!m_busy) begin
            if (BrValid) begin
                m_busy = 1; m_cond = BrCond; m_tgt = BrTarget;
                if (FlagPend && BrCond != 2'd0) m_waiting = 1;
                else m_resolve = 1;
            end
        end else if (done_e) begin
            m_waiting = 0; m_resolve = 0;
            if (taken_e && FLUSH_CYC > 1) m_flush_left = FLUSH_CYC - 1;
            else m_busy = 0;
        end else if (m_waiting) begin
            if (FlagWe) begin m_waiting = 0; m_resolve = 1; end
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) m_busy = 0;
        end
        if (FlagWe) m_flags = FlagIn;
    endtask

    task automatic step(input logic v, input logic [1:0] c, input logic [15:0] t,
                        input logic p, input logic we, input logic [3:0] fi);
        @(posedge Clock); #1;
        BrValid = v; BrCond = c; BrTarget = t; FlagPend = p; FlagWe = we; FlagIn = fi;
        @(negedge Clock);
        check_and_advance();
    endtask

    // Reset is applied and released between clock edges, then the reset state is checked.
    task automatic pulse_reset();
        @(posedge Clock); #1;
        Resetn = 0; BrValid = 0; FlagWe = 0; FlagPend = 0;
        #1;
        model_reset();
        chk("rst_ready", 32'(BrReady), 32'd1);
        chk("rst_out", 32'({Stall, BrDone, BrTaken, PcLoad, Flush}), 32'd0);
        chk("rst_flags", 32'(FlagReg), 32'd0);
        chk("rst_target", 32'(PcTarget), 32'd0);
        @(negedge Clock); @(negedge Clock);
        Resetn = 1;
    endtask

    initial begin
        model_reset();
        pulse_reset();
        // Unconditional branch with no pending flags: taken, then two Flush cycles.
        step(1, 2'b00, 16'h0040, 0, 0, 4'h0);
        repeat (4) step(0, 2'b00, 16'h0, 0, 0, 4'h0);
        // EQ with Z clear: not taken.
        step(1, 2'b01, 16'h1234, 0, 0, 4'h0);
        repeat (3) step(0, 2'b00, 16'h0, 0, 0, 4'h0);
        // LT waiting on a pending flag write.
        step(1, 2'b11, 16'h0abc, 1, 0, 4'h0);
        step(0, 2'b00, 16'h0, 0, 0, 4'h0);
        step(0, 2'b00, 16'h0, 1, 0, 4'h0);
        step(0, 2'b00, 16'h0, 0, 1, 4'b1000);
        repeat (4) step(0, 2'b00, 16'h0, 0, 0, 4'h0);
        // GE: a flag write in the evaluate cycle is not seen by the resolution.
        step(0, 2'b00, 16'h0, 0, 1, 4'b1000);
        step(1, 2'b10, 16'h0200, 0, 0, 4'h0);
        step(0, 2'b00, 16'h0, 0, 1, 4'b0000);
        repeat (3) step(0, 2'b00, 16'h0, 0, 0, 4'h0);
        // Reset while the branch waits on flags; the branch must not resolve later.
        step(1, 2'b01, 16'h0300, 1, 0, 4'h0);
        step(0, 2'b00, 16'h0, 0, 0, 4'h0);
        pulse_reset();
        step(0, 2'b00, 16'h0, 0, 1, 4'h4);
        step(0, 2'b00, 16'h0, 0, 1, 4'h0);
        step(0, 2'b00, 16'h0, 0, 0, 4'h0);
        // Random traffic, with reset pulsed occasionally.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(199) == 0) pulse_reset();
            step($urandom_range(1), 2'($urandom_range(3)), 16'($urandom),
                 ($urandom_range(1) == 1), ($urandom_range(3) == 0), 4'($urandom_range(15)));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
